// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester-side and datapath-side signals for mult_share_arbiter.
// The arbiter connects through the slave modport; the environment that drives
// requests and models the shared multiplier uses the master modport.
interface mult_share_arbiter_if;
    // Requester 0/1 handshake and operands
    logic       req0;
    logic       req1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       done0;
    logic       done1;
    logic [7:0] result;
    logic       err;
    logic       busy;

    // Shared multiplier datapath
    logic [3:0] dp_a;
    logic [3:0] dp_b;
    logic       dp_clr;
    logic       dp_en;
    logic       dp_done;
    logic [7:0] dp_out;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, dp_done, dp_out,
        output done0, done1, result, err, busy, dp_a, dp_b, dp_clr, dp_en
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, dp_done, dp_out,
        input  done0, done1, result, err, busy, dp_a, dp_b, dp_clr, dp_en
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier datapath between two requesters.
// Each grant runs IDLE -> CLEAR -> RUN -> RESP; RUN ends on dp_done or after
// TIMEOUT cycles, and RESP pulses done for the served requester only.
module mult_share_arbiter #(
    parameter int TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e     state_q,  state_d;
    logic       grant_q,  grant_d;   // requester currently being served
    logic       prio_q,   prio_d;    // requester that wins when both ask
    logic [3:0] dp_a_q,   dp_a_d;
    logic [3:0] dp_b_q,   dp_b_d;
    logic [7:0] count_q,  count_d;   // RUN cycles elapsed
    logic [7:0] result_q, result_d;
    logic       err_q,    err_d;
    logic       pick;                // arbitration winner for this cycle
    logic       count_hit;           // this RUN cycle is the last one allowed

    // Arbitration: a lone request always wins, a tie goes to the priority holder.
    always_comb begin
        pick = prio_q;
        if (bus.req0 && !bus.req1) begin
            pick = 1'b0;
        end else if (bus.req1 && !bus.req0) begin
            pick = 1'b1;
        end
    end

    assign count_hit = ((count_q + 8'd1) == TIMEOUT_C);

    // Next-state logic: sequencing, operand latch, timeout and result capture.
    always_comb begin
        // NOTE: every next-state signal is defaulted to hold first, so no path through the case leaves one unassigned and infers a latch.
        state_d  = state_q;
        grant_d  = grant_q;
        prio_d   = prio_q;
        dp_a_d   = dp_a_q;
        dp_b_d   = dp_b_q;
        count_d  = count_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_d = pick;
                    dp_a_d  = pick ? bus.a1 : bus.a0;
                    dp_b_d  = pick ? bus.b1 : bus.b0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                count_d = 8'd0;
                state_d = RUN;
            end
            RUN: begin
                count_d = count_q + 8'd1;
                // A completed product beats a timeout landing on the same cycle.
                if (bus.dp_done) begin
                    result_d = bus.dp_out;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (count_hit) begin
                    result_d = 8'h00;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                prio_d  = ~grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, and every register, including the operand and result holders, gets an explicit reset value.
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            prio_q   <= 1'b0;
            dp_a_q   <= 4'd0;
            dp_b_q   <= 4'd0;
            count_q  <= 8'd0;
            result_q <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            prio_q   <= prio_d;
            dp_a_q   <= dp_a_d;
            dp_b_q   <= dp_b_d;
            count_q  <= count_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode only registered state, so req never reaches done in the same cycle.
    assign bus.done0  = (state_q == RESP) && !grant_q;
    assign bus.done1  = (state_q == RESP) &&  grant_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.dp_clr = (state_q == CLEAR);
    assign bus.dp_en  = (state_q == RUN);
    assign bus.dp_a   = dp_a_q;
    assign bus.dp_b   = dp_b_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: a transaction-level model predicts every
// cycle's outputs from grant time and datapath latency, a datapath model
// answers with the product after a chosen number of RUN cycles, and directed
// scenarios pin the model with hand-computed values before a random phase.
module tb_mult_share_arbiter;
    localparam int TIMEOUT = 31;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_share_arbiter_if bus ();

    mult_share_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
    endtask

    // Datapath latency handed to the next grant (0 means the product never arrives).
    int lat_next = 1;
    int cur_lat  = 1;
    int run_cnt  = 0;

    // Datapath model: counts RUN cycles since the clear strobe, raises dp_done
    // from RUN cycle cur_lat onward, and presents the product of dp_a*dp_b.
    initial begin
        bus.dp_done = 1'b0;
        bus.dp_out  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.dp_clr) begin
                run_cnt     = 0;
                bus.dp_done = 1'b0;
            end else if (bus.dp_en) begin
                run_cnt++;
                bus.dp_done = (cur_lat != 0) && (run_cnt >= cur_lat);
            end else begin
                bus.dp_done = 1'b0;
            end
            bus.dp_out = bus.dp_done ? ({4'b0, bus.dp_a} * {4'b0, bus.dp_b}) : 8'hA5;
        end
    end

    // Transaction model: a grant decided in idle cycle g with n RUN cycles gives
    // CLEAR at g+1, RUN at g+2..g+1+n, RESP at g+2+n, idle again afterwards.
    int         cyc      = 0;
    bit         op_valid = 1'b0;
    int         gcyc     = 0;
    int         resp_c   = 0;
    int         nrun     = 0;
    bit         op_req   = 1'b0;
    bit         op_err   = 1'b0;
    logic [3:0] op_a     = 4'd0;
    logic [3:0] op_b     = 4'd0;
    logic [7:0] op_res   = 8'd0;
    logic [3:0] exp_a    = 4'd0;
    logic [3:0] exp_b    = 4'd0;
    logic [7:0] exp_res  = 8'd0;
    bit         exp_err  = 1'b0;
    bit         prio     = 1'b0;
    bit         g        = 1'b0;
    bit         fl       = 1'b0;
    bit         e_clr    = 1'b0;
    bit         e_en     = 1'b0;
    bit         e_done   = 1'b0;
    bit         seen_done0 = 1'b0;
    bit         seen_done1 = 1'b0;

    // Compare process: checks every output against the model each cycle.
    always @(negedge clk) begin
        cyc++;
        seen_done0 = bus.done0;
        seen_done1 = bus.done1;
        check("en_and_clr", {31'd0, bus.dp_en & bus.dp_clr}, 0);
        check("one_done",   {31'd0, bus.done0 & bus.done1}, 0);
        if (!rst) begin
            op_valid = 1'b0;
            exp_a = 4'd0; exp_b = 4'd0; exp_res = 8'd0; exp_err = 1'b0; prio = 1'b0;
            fl = 1'b0; e_clr = 1'b0; e_en = 1'b0; e_done = 1'b0;
        end else begin
            fl     = op_valid && (cyc <= resp_c);
            e_clr  = fl && (cyc == gcyc + 1);
            e_en   = fl && (cyc >= gcyc + 2) && (cyc < resp_c);
            e_done = fl && (cyc == resp_c);
            if (e_clr) begin exp_a = op_a; exp_b = op_b; end
            if (e_done) begin exp_res = op_res; exp_err = op_err; prio = !op_req; end
        end
        check("done0",  bus.done0,  e_done && !op_req);
        check("done1",  bus.done1,  e_done && op_req);
        check("busy",   bus.busy,   fl);
        check("dp_clr", bus.dp_clr, e_clr);
        check("dp_en",  bus.dp_en,  e_en);
        check("dp_a",   bus.dp_a,   exp_a);
        check("dp_b",   bus.dp_b,   exp_b);
        check("result", bus.result, exp_res);
        check("err",    bus.err,    exp_err);
        if (rst && !fl && (bus.req0 || bus.req1)) begin
            g = (bus.req0 && bus.req1) ? prio : bus.req1;
            op_req = g;
            op_a = g ? bus.a1 : bus.a0;
            op_b = g ? bus.b1 : bus.b0;
            if (lat_next != 0 && lat_next <= TIMEOUT) begin
                nrun   = lat_next;
                op_err = 1'b0;
                op_res = {4'b0, op_a} * {4'b0, op_b};
            end else begin
                nrun   = TIMEOUT;
                op_err = 1'b1;
                op_res = 8'h00;
            end
            cur_lat  = lat_next;
            gcyc     = cyc;
            resp_c   = cyc + 2 + nrun;
            op_valid = 1'b1;
        end
    end

    // Waits a bounded number of cycles for a done pulse, counting RUN cycles seen.
    task automatic wait_done(input int budget, output int cycles, output int runs);
        bit ok;
        cycles = 0;
        runs   = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (bus.dp_en) runs++;
            if (bus.done0 || bus.done1) ok = 1'b1;
        end
        check("done_seen", {31'd0, ok}, 1);
    endtask

    task automatic rand_req(input bit seen, inout logic req, inout logic [3:0] a, inout logic [3:0] b);
        if (!req) begin
            if ($urandom_range(2) == 0) begin
                req = 1'b1; a = 4'($urandom); b = 4'($urandom);
            end
        end else if (seen) begin
            if ($urandom_range(3) != 0) req = 1'b0;
            else begin a = 4'($urandom); b = 4'($urandom); end
        end else if ($urandom_range(59) == 0) begin
            req = 1'b0;
        end else if ($urandom_range(7) == 0) begin
            a = 4'($urandom); b = 4'($urandom);
        end
    endtask

    int n_cyc;
    int n_run;
    int exp_order [4] = '{0, 1, 0, 1};
    int exp_prod  [4] = '{8, 63, 8, 63};

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = 4'd0; bus.b0 = 4'd0; bus.a1 = 4'd0; bus.b1 = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {bus.done0, bus.done1, bus.err, bus.busy, bus.dp_en,
                              bus.dp_clr, bus.result, bus.dp_a, bus.dp_b}, 0);

        // Single request 3*5 with a 3-cycle datapath; grant on first edge after release
        // NOTE: stimulus is driven with blocking assignments 1 time unit after the rising edge, so the design never samples a changing input.
        @(posedge clk); #1;
        rst = 1'b1; bus.req0 = 1'b1; bus.a0 = 4'd3; bus.b0 = 4'd5; lat_next = 3;
        wait_done(20, n_cyc, n_run);
        check("t1_cycles", n_cyc, 6);
        check("t1_runs",   n_run, 3);
        check("t1_done0",  bus.done0, 1);
        check("t1_result", bus.result, 15);
        check("t1_err",    bus.err, 0);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        @(negedge clk);
        check("t1_idle", bus.busy, 0);

        // Minimum latency: dp_done on the first RUN cycle
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.a0 = 4'd6; bus.b0 = 4'd7; lat_next = 1;
        wait_done(20, n_cyc, n_run);
        check("t2_cycles", n_cyc, 4);
        check("t2_result", bus.result, 42);
        @(posedge clk); #1;
        bus.req0 = 1'b0;

        // Both requesting from reset: order alternates 0,1,0,1
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 4'd2; bus.b0 = 4'd4;
        bus.req1 = 1'b1; bus.a1 = 4'd7; bus.b1 = 4'd9;
        lat_next = 2;
        for (int k = 0; k < 4; k++) begin
            wait_done(20, n_cyc, n_run);
            check("t3_order",  {31'd0, bus.done1}, exp_order[k]);
            check("t3_result", bus.result, exp_prod[k]);
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Datapath never completes: exactly TIMEOUT RUN cycles, then err
        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.a1 = 4'd5; bus.b1 = 4'd5; lat_next = 0;
        wait_done(60, n_cyc, n_run);
        check("t4_runs",   n_run, 31);
        check("t4_done1",  bus.done1, 1);
        check("t4_err",    bus.err, 1);
        check("t4_result", bus.result, 0);
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        @(negedge clk);
        check("t4_busy_drop", bus.busy, 0);
        check("t4_err_hold",  bus.err, 1);

        // Product arrives on the timeout cycle itself: completion wins
        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.a1 = 4'd3; bus.b1 = 4'd11; lat_next = TIMEOUT;
        wait_done(60, n_cyc, n_run);
        check("t5_runs",   n_run, 31);
        check("t5_err",    bus.err, 0);
        check("t5_result", bus.result, 33);
        @(posedge clk); #1;
        bus.req1 = 1'b0;

        // Operand change during RUN is ignored
        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.a1 = 4'd4; bus.b1 = 4'd2; lat_next = 5;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        bus.a1 = 4'd9;
        wait_done(20, n_cyc, n_run);
        check("t6_dp_a",   bus.dp_a, 4);
        check("t6_result", bus.result, 8);
        @(posedge clk); #1;
        bus.req1 = 1'b0;

        // Reset during RUN: outputs clear at once, no done, later request completes
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.a0 = 4'd15; bus.b0 = 4'd15; lat_next = 0;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t7_rst_outputs", {bus.done0, bus.done1, bus.err, bus.busy, bus.dp_en,
                                 bus.dp_clr, bus.result, bus.dp_a, bus.dp_b}, 0);
        repeat (2) begin
            @(negedge clk);
            check("t7_no_done", {31'd0, bus.done0 | bus.done1}, 0);
        end
        lat_next = 2;
        @(posedge clk); #1;
        rst = 1'b1;
        wait_done(20, n_cyc, n_run);
        check("t7_done0",  bus.done0, 1);
        check("t7_result", bus.result, 225);
        @(posedge clk); #1;
        bus.req0 = 1'b0;

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            if ($urandom_range(499) == 0) rst = 1'b0;
            rand_req(seen_done0, bus.req0, bus.a0, bus.b0);
            rand_req(seen_done1, bus.req1, bus.a1, bus.b1);
            case ($urandom_range(9))
                0:       lat_next = 0;
                1:       lat_next = TIMEOUT;
                2:       lat_next = TIMEOUT + 1;
                default: lat_next = $urandom_range(6, 1);
            endcase
        end

        // Drain any operation still in flight
        @(posedge clk); #1;
        rst = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (TIMEOUT + 10) @(posedge clk);
        @(negedge clk);
        check("final_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
